// File: rtl/keypad_key_buffer.sv
// rtl/keypad_key_buffer.sv - keypad digit/Enter/Esc capture buffer (optional debounce via DEBOUNCE_EN)
module keypad_key_buffer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_digit,
    input  logic [3:0]  key_digit,
    input  logic        btn_enter,
    input  logic        btn_esc,
    input  logic        clrBuffer,
    output logic [1:0]  KeyCode,
    output logic        KeyCodeAvailable,
    output logic [23:0] hhmmss,
    output logic [2:0]  digit_count
);

    // Button vectors are packed as {esc, enter, digit}.
    localparam int BTN_DIGIT = 0;
    localparam int BTN_ENTER = 1;
    localparam int BTN_ESC   = 2;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce_cycles
        $error("keypad_key_buffer: DEBOUNCE_CYCLES must be in 2..65535");
    end

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [3:0] key_sync1;
    logic [3:0] key_sync2;
    logic [2:0] level;
    logic [2:0] level_prev;
    logic [2:0] press;

    // Two-flop synchronizer; the digit value rides the same pipeline as its button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            key_sync1 <= '0;
            key_sync2 <= '0;
        end else begin
            sync1     <= {btn_esc, btn_enter, btn_digit};
            sync2     <= sync1;
            key_sync1 <= key_digit;
            key_sync2 <= key_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] db_cnt [3];

    // Per button: flip the debounced level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                level[i]  <= 1'b0;
                db_cnt[i] <= '0;
            end else if (sync2[i] == level[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
                level[i]  <= ~level[i];
                db_cnt[i] <= '0;
            end else begin
                db_cnt[i] <= db_cnt[i] + 16'd1;
            end
        end
    end

    // Edge detector; a button held through reset debounces up and presses once.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_prev <= '0;
        end else begin
            level_prev <= level;
        end
    end

    assign press = level & ~level_prev;
`else
    logic [1:0] prime_cnt;
    logic       armed;

    assign level = sync2;
    assign armed = (prime_cnt == 2'd2);

    // Counts the two cycles the synchronizer needs to refill with real samples after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= '0;
        end else if (!armed) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // Edge detector; treated as already high until armed so a button held through reset needs a re-press.
    always_ff @(posedge clk) begin
        if (reset || !armed) begin
            level_prev <= '1;
        end else begin
            level_prev <= level;
        end
    end

    assign press = level & ~level_prev & {3{armed}};
`endif

    // Key code and digit buffer; clrBuffer clears and swallows same-cycle events, pending code blocks everything.
    always_ff @(posedge clk) begin
        if (reset || clrBuffer) begin
            KeyCode          <= 2'b00;
            KeyCodeAvailable <= 1'b0;
            hhmmss           <= '0;
            digit_count      <= '0;
        end else if (!KeyCodeAvailable) begin
            if (press[BTN_ESC]) begin
                KeyCode          <= 2'b10;
                KeyCodeAvailable <= 1'b1;
            end else if (press[BTN_ENTER]) begin
                KeyCode          <= 2'b01;
                KeyCodeAvailable <= 1'b1;
            end else if (press[BTN_DIGIT] && key_sync2 <= 4'd9 && digit_count < 3'd6) begin
                hhmmss      <= {hhmmss[19:0], key_sync2};
                digit_count <= digit_count + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_key_buffer.sv
// tb/tb_keypad_key_buffer.sv - self-checking bench for keypad_key_buffer (default and DEBOUNCE_EN builds)
module tb_keypad_key_buffer;

`ifdef DEBOUNCE_EN
    localparam int DEB_ON = 1;
    localparam int DC     = 4;
`else
    localparam int DEB_ON = 0;
    localparam int DC     = 16;
`endif
    localparam int LAT  = DEB_ON ? 3 + DC : 3;
    localparam int HOLD = LAT + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_digit;
    logic [3:0]  key_digit;
    logic        btn_enter;
    logic        btn_esc;
    logic        clrBuffer;
    logic [1:0]  KeyCode;
    logic        KeyCodeAvailable;
    logic [23:0] hhmmss;
    logic [2:0]  digit_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0]  m_code;
    logic        m_avail;
    logic [23:0] m_hms;
    int          m_cnt;

    keypad_key_buffer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_digit        (btn_digit),
        .key_digit        (key_digit),
        .btn_enter        (btn_enter),
        .btn_esc          (btn_esc),
        .clrBuffer        (clrBuffer),
        .KeyCode          (KeyCode),
        .KeyCodeAvailable (KeyCodeAvailable),
        .hhmmss           (hhmmss),
        .digit_count      (digit_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".KeyCode"}, 24'(KeyCode), 24'(m_code));
        chk({tag, ".avail"}, 24'(KeyCodeAvailable), 24'(m_avail));
        chk({tag, ".hhmmss"}, hhmmss, m_hms);
        chk({tag, ".count"}, 24'(digit_count), 24'(m_cnt));
    endtask

    // Reference behaviour: one press event (any combination of buttons in the same cycle).
    task automatic m_event(input bit d, input bit e, input bit s, input int k);
        if (m_avail) return;
        if (s) begin
            m_code = 2'b10; m_avail = 1'b1;
        end else if (e) begin
            m_code = 2'b01; m_avail = 1'b1;
        end else if (d && k <= 9 && m_cnt < 6) begin
            m_hms = {m_hms[19:0], 4'(k)};
            m_cnt++;
        end
    endtask

    task automatic m_clear();
        m_code = 2'b00; m_avail = 1'b0; m_hms = '0; m_cnt = 0;
    endtask

    task automatic press_multi(input bit d, input bit e, input bit s, input int k);
        key_digit = 4'(k);
        btn_digit = d; btn_enter = e; btn_esc = s;
        step(HOLD);
        btn_digit = 1'b0; btn_enter = 1'b0; btn_esc = 1'b0;
        step(HOLD);
        if (!clrBuffer) m_event(d, e, s, k);
    endtask

    task automatic pulse_clr();
        clrBuffer = 1'b1;
        step(1);
        clrBuffer = 1'b0;
        m_clear();
    endtask

    initial begin
        int dl[6];
        reset = 1'b1; btn_digit = 1'b0; key_digit = '0; btn_enter = 1'b0;
        btn_esc = 1'b0; clrBuffer = 1'b0;
        m_clear();
        step(2);
        chk_all("reset");
        reset = 1'b0;
        step(4);

        // Digit 1 with latency check, then 2,3,0,4,5 and an overflow digit 7.
        key_digit = 4'd1; btn_digit = 1'b1;
        step(LAT - 1);
        chk("latency.before", 24'(digit_count), 24'd0);
        step(1);
        chk("latency.at", 24'(digit_count), 24'd1);
        step(HOLD - LAT);
        btn_digit = 1'b0;
        step(HOLD);
        m_event(1, 0, 0, 1);
        dl = '{2, 3, 0, 4, 5, 7};
        foreach (dl[i]) press_multi(1, 0, 0, dl[i]);
        chk("digits.hhmmss", hhmmss, 24'h123045);
        chk("digits.count", 24'(digit_count), 24'd6);
        chk_all("digits");

        // Enter, Esc while pending, clear.
        pulse_clr();
        press_multi(0, 1, 0, 0);
        chk("enter.code", 24'(KeyCode), 24'h1);
        press_multi(0, 0, 1, 0);
        chk("esc_pending.code", 24'(KeyCode), 24'h1);
        pulse_clr();
        chk_all("clr");

        // Simultaneous events.
        press_multi(0, 1, 1, 0);
        chk("enter_esc.code", 24'(KeyCode), 24'h2);
        pulse_clr();
        press_multi(1, 0, 0, 2);
        press_multi(1, 1, 0, 5);
        chk("digit_enter.count", 24'(digit_count), 24'd1);
        chk("digit_enter.code", 24'(KeyCode), 24'h1);
        chk_all("simul");
        pulse_clr();

        // Invalid digit.
        press_multi(1, 0, 0, 10);
        chk("invalid.count", 24'(digit_count), 24'd0);

`ifdef DEBOUNCE_EN
        // Bouncing digit 9 never settles, then a clean hold enters it once.
        key_digit = 4'd9;
        for (int i = 0; i < 5; i++) begin
            btn_digit = 1'b1; step(2);
            btn_digit = 1'b0; step(2);
        end
        chk("bounce.count", 24'(digit_count), 24'd0);
        btn_digit = 1'b1; step(10);
        btn_digit = 1'b0; step(HOLD);
        m_event(1, 0, 0, 9);
        chk("debounce.digit", 24'(hhmmss[3:0]), 24'h9);
        chk_all("debounce");
`endif

        // Three digits then reset while Enter is held.
        press_multi(1, 0, 0, 3);
        press_multi(1, 0, 0, 8);
        press_multi(1, 0, 0, 6);
        chk_all("pre_reset");
        btn_enter = 1'b1; reset = 1'b1;
        step(1);
        reset = 1'b0;
        m_clear();
        chk_all("mid_reset");
        step(2 * HOLD);
        if (DEB_ON != 0) m_event(0, 1, 0, 0);
        chk_all("held_enter");
        btn_enter = 1'b0;
        step(HOLD);
        press_multi(0, 1, 0, 0);
        chk_all("re_press");
        pulse_clr();

        // Randomized operations against the reference model.
        for (int op = 0; op < 60; op++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel <= 4) begin
                press_multi(1, 0, 0, int'($urandom_range(0, 11)));
            end else if (sel == 5) begin
                press_multi(0, 1, 0, 0);
            end else if (sel == 6) begin
                press_multi(0, 0, 1, 0);
            end else if (sel == 7) begin
                press_multi(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 11)));
            end else if (sel == 8) begin
                pulse_clr();
            end else begin
                clrBuffer = 1'b1;
                press_multi(1, 1'($urandom), 1'($urandom), int'($urandom_range(0, 9)));
                clrBuffer = 1'b0;
                m_clear();
                step(1);
            end
            chk_all($sformatf("rand%0d", op));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_key_buffer.md
KEYPAD_KEY_BUFFER -- requirements
Module: keypad_key_buffer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles before a debounced level changes; legal range 2..65535.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, synchronous, active-high reset.
- btn_digit, in, 1, raw asynchronous digit-key press level.
- key_digit, in, 4, digit value; sampled with btn_digit through the same synchronizer.
- btn_enter, in, 1, raw asynchronous Enter button level.
- btn_esc, in, 1, raw asynchronous Esc button level.
- clrBuffer, in, 1, consumer acknowledge: clear the code and the digit buffer.
- KeyCode, out, 2, 2'b01 = Enter, 2'b10 = Esc, 2'b00 = none.
- KeyCodeAvailable, out, 1, a KeyCode is pending; held until clrBuffer.
- hhmmss, out, 24, six BCD digits, most recently entered digit in [3:0].
- digit_count, out, 3, number of digits entered, 0..6.

Function
REQ-003 Each raw button passes a 2-flop synchronizer. key_digit is registered alongside btn_digit.
REQ-004 A press event is the rising edge of the debounced level: one pulse per physical press. Releases generate nothing.
REQ-005 Outputs update on the clock edge after the edge on which the debounced level rises.
REQ-006 Enter event with KeyCodeAvailable=0: KeyCode<=2'b01 and KeyCodeAvailable<=1.
REQ-007 Esc event with KeyCodeAvailable=0: KeyCode<=2'b10 and KeyCodeAvailable<=1.
REQ-008 Enter and Esc events in the same cycle: Esc wins.
REQ-009 Digit event, all conditions true (KeyCodeAvailable=0, key_digit<=9, digit_count<6, no Enter/Esc event that cycle):
- hhmmss<={hhmmss[19:0],key_digit};
- digit_count increments by 1.
REQ-010 Digit events are dropped with no state change when any of these holds:
- key_digit>9;
- digit_count=6 (saturated);
- KeyCodeAvailable=1;
- a simultaneous Enter or Esc event is present.
REQ-011 While KeyCodeAvailable=1, Enter and Esc events are ignored. KeyCode, hhmmss and digit_count hold.
REQ-012 clrBuffer sampled high: next edge sets KeyCode<=0, KeyCodeAvailable<=0, hhmmss<=0, digit_count<=0.
- Any event in that same cycle is dropped.
- clrBuffer while KeyCodeAvailable=0 still clears hhmmss and digit_count.
REQ-013 clrBuffer held high for multiple cycles keeps the block cleared and drops all events in those cycles.
REQ-014 hhmmss is not range-checked as a time value; the consumer validates it.

Reset
REQ-015 reset=1 at a clock edge sets the following to 0: KeyCode, KeyCodeAvailable, hhmmss, digit_count, synchronizer flops, debounced levels, debounce counters.
REQ-016 reset has priority over clrBuffer and all events.
REQ-017 A button held high across reset release does not produce an event until it is released and pressed again.
- The debounced level first rises to 1 and generates one event.
- Exception: with DEBOUNCE_EN, a button held continuously across release produces one event after DEBOUNCE_CYCLES.

Configuration
REQ-018 Macro DEBOUNCE_EN selects the debounce behaviour.
- Defined: per button, a counter counts consecutive cycles in which the synchronized level differs from the debounced level.
  - The counter resets to 0 on any cycle the two agree.
  - The debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
- Undefined: debounced level = synchronizer output. No counters are built and DEBOUNCE_CYCLES is unused.

Verification
REQ-019 Directed scenarios:
- Digit sequence with DEBOUNCE_EN off: press digits 1,2,3,0,4,5 (clean pulses) -> hhmmss=24'h123045, digit_count=6. Then press 7 -> no change.
- Enter, then clrBuffer: press Enter -> KeyCode=01, KeyCodeAvailable=1. Press Esc while pending -> KeyCode stays 01. Pulse clrBuffer -> all outputs 0 next cycle.
- Simultaneous events: Enter and Esc rise in the same cycle -> KeyCode=10. Digit 5 and Enter together -> digit_count unchanged, KeyCode=01.
- Debounce, DEBOUNCE_EN on, DEBOUNCE_CYCLES=4: btn_digit (key 9) toggling every 2 cycles for 20 cycles -> no event. Then held 10 cycles -> exactly one digit entered, hhmmss[3:0]=9.
- Invalid digit and mid-operation reset: key_digit=4'hA press -> ignored. Enter 3 digits, then assert reset 1 cycle while btn_enter is held -> all outputs 0, no Enter event until re-press.
